// File: rtl/core_id_sb_if.sv
// rtl/core_id_sb_if.sv - fetch, writeback and decode handshake bundle for core_id_sb
interface core_id_sb_if;
    // fetch -> decode
    logic        fd_valid;
    logic        fd_ready;
    logic [31:0] fd_istr;
    logic [31:0] fd_pc;
    logic        fd_jump;

    // execute squash
    logic        ex_flush_en;

    // writeback -> register file / scoreboard
    logic        wd_valid;
    logic        wd_reg_write;
    logic [4:0]  wd_rd;
    logic [31:0] wd_reg_data;
    logic        wd_ready;

    // decode -> execute
    logic        de_valid;
    logic        de_ready;
    logic [3:0]  de_alu_op;
    logic [31:0] de_rs1_value;
    logic [31:0] de_rs2_value;
    logic [31:0] de_imm;
    logic [31:0] de_pc;
    logic [4:0]  de_rd;
    logic        de_reg_write;
    logic        de_mem_read;
    logic        de_mem_write;
    logic        de_is_br;
    logic        de_jump;
    logic        de_illegal;

    modport slave (
        input  fd_valid, fd_istr, fd_pc, fd_jump,
        input  ex_flush_en,
        input  wd_valid, wd_reg_write, wd_rd, wd_reg_data,
        input  de_ready,
        output fd_ready, wd_ready,
        output de_valid, de_alu_op, de_rs1_value, de_rs2_value, de_imm, de_pc,
        output de_rd, de_reg_write, de_mem_read, de_mem_write, de_is_br,
        output de_jump, de_illegal
    );

    modport master (
        output fd_valid, fd_istr, fd_pc, fd_jump,
        output ex_flush_en,
        output wd_valid, wd_reg_write, wd_rd, wd_reg_data,
        output de_ready,
        input  fd_ready, wd_ready,
        input  de_valid, de_alu_op, de_rs1_value, de_rs2_value, de_imm, de_pc,
        input  de_rd, de_reg_write, de_mem_read, de_mem_write, de_is_br,
        input  de_jump, de_illegal
    );
endinterface

// File: rtl/core_id_sb.sv
// rtl/core_id_sb.sv - RV32I fetch buffer, decoder, register file and write scoreboard
module core_id_sb #(
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_INFLIGHT = 3,
    parameter int BYPASS_EN    = 1
) (
    input  logic         clk,
    input  logic         rest,
    core_id_sb_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // fetch buffer: one extra pointer bit distinguishes full from empty
    logic [64:0]   fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          issue;
    logic [64:0]   head;
    logic [31:0]   h_istr;
    logic [31:0]   h_pc;
    logic          h_jump;

    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty  = (wr_ptr == rd_ptr);
    assign push   = bus.fd_valid && !full && !bus.ex_flush_en;
    assign head   = fifo_mem[rd_ptr[AW-1:0]];
    assign h_istr = head[64:33];
    assign h_pc   = head[32:1];
    assign h_jump = head[0];

    assign bus.fd_ready = !full;
    assign bus.wd_ready = 1'b1;

    // buffer storage carries no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {bus.fd_istr, bus.fd_pc, bus.fd_jump};
        end
    end

    // pointer update: a flush drops everything buffered, including a coinciding push
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.ex_flush_en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // field extraction for the instruction at the head of the buffer
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opc   = h_istr[6:0];
    assign rd    = h_istr[11:7];
    assign f3    = h_istr[14:12];
    assign rs1   = h_istr[19:15];
    assign rs2   = h_istr[24:20];
    assign f7    = h_istr[31:25];
    assign imm_i = {{20{h_istr[31]}}, h_istr[31:20]};
    assign imm_s = {{20{h_istr[31]}}, h_istr[31:25], h_istr[11:7]};
    assign imm_b = {{19{h_istr[31]}}, h_istr[31], h_istr[7], h_istr[30:25], h_istr[11:8], 1'b0};
    assign imm_u = {h_istr[31:12], 12'b0};
    assign imm_j = {{11{h_istr[31]}}, h_istr[31], h_istr[19:12], h_istr[20], h_istr[30:21], 1'b0};

    logic [3:0]  d_alu;
    logic [31:0] d_imm;
    logic        d_rw;
    logic        d_mr;
    logic        d_mw;
    logic        d_br;
    logic        d_ill;
    logic        use1;
    logic        use2;

    // decode the head instruction; illegal encodings collapse to a harmless no-op
    always_comb begin
        d_alu = ALU_ADD;
        d_imm = '0;
        d_rw  = 1'b0;
        d_mr  = 1'b0;
        d_mw  = 1'b0;
        d_br  = 1'b0;
        d_ill = 1'b0;
        use1  = 1'b0;
        use2  = 1'b0;
        case (opc)
            OPC_OP: begin
                use1 = 1'b1;
                use2 = 1'b1;
                d_rw = 1'b1;
                if (f7 == F7_ZERO) begin
                    case (f3)
                        3'd0:    d_alu = ALU_ADD;
                        3'd1:    d_alu = ALU_SLL;
                        3'd2:    d_alu = ALU_SLT;
                        3'd3:    d_alu = ALU_SLTU;
                        3'd4:    d_alu = ALU_XOR;
                        3'd5:    d_alu = ALU_SRL;
                        3'd6:    d_alu = ALU_OR;
                        default: d_alu = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'd0) begin
                    d_alu = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'd5) begin
                    d_alu = ALU_SRA;
                end else begin
                    d_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                use1  = 1'b1;
                d_rw  = 1'b1;
                d_imm = imm_i;
                case (f3)
                    3'd0: d_alu = ALU_ADD;
                    3'd2: d_alu = ALU_SLT;
                    3'd3: d_alu = ALU_SLTU;
                    3'd4: d_alu = ALU_XOR;
                    3'd6: d_alu = ALU_OR;
                    3'd7: d_alu = ALU_AND;
                    3'd1: begin
                        d_alu = ALU_SLL;
                        if (f7 != F7_ZERO) d_ill = 1'b1;
                    end
                    default: begin
                        if (f7 == F7_ZERO) d_alu = ALU_SRL;
                        else if (f7 == F7_ALT) d_alu = ALU_SRA;
                        else d_ill = 1'b1;
                    end
                endcase
            end
            OPC_LOAD: begin
                use1  = 1'b1;
                d_rw  = 1'b1;
                d_mr  = 1'b1;
                d_imm = imm_i;
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) d_ill = 1'b1;
            end
            OPC_STORE: begin
                use1  = 1'b1;
                use2  = 1'b1;
                d_mw  = 1'b1;
                d_imm = imm_s;
                if (f3 > 3'd2) d_ill = 1'b1;
            end
            OPC_BRANCH: begin
                use1  = 1'b1;
                use2  = 1'b1;
                d_br  = 1'b1;
                d_imm = imm_b;
                if (f3 == 3'd2 || f3 == 3'd3) d_ill = 1'b1;
            end
            OPC_JAL: begin
                d_rw  = 1'b1;
                d_imm = imm_j;
            end
            OPC_JALR: begin
                use1  = 1'b1;
                d_rw  = 1'b1;
                d_imm = imm_i;
                if (f3 != 3'd0) d_ill = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                d_rw  = 1'b1;
                d_imm = imm_u;
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_alu = ALU_ADD;
            d_imm = '0;
            d_rw  = 1'b0;
            d_mr  = 1'b0;
            d_mw  = 1'b0;
            d_br  = 1'b0;
            use1  = 1'b0;
            use2  = 1'b0;
        end
        if (rd == 5'd0) begin
            d_rw = 1'b0;
        end
    end

    // register file and pending-write scoreboard
    logic [31:0]   rf  [32];
    logic [CW-1:0] cnt [32];
    logic          wb_fire;
    logic          byp1;
    logic          byp2;
    logic          haz1;
    logic          haz2;
    logic          haz_rd;
    logic          hazard;
    logic [31:0]   rs1_val;
    logic [31:0]   rs2_val;

    assign wb_fire = bus.wd_valid && bus.wd_reg_write && (bus.wd_rd != 5'd0);
    assign byp1    = (BYPASS_EN != 0) && wb_fire && (bus.wd_rd == rs1);
    assign byp2    = (BYPASS_EN != 0) && wb_fire && (bus.wd_rd == rs2);
    assign haz1    = use1 && (rs1 != 5'd0) && (cnt[rs1] != '0) && !(byp1 && cnt[rs1] == CNT_ONE);
    assign haz2    = use2 && (rs2 != 5'd0) && (cnt[rs2] != '0) && !(byp2 && cnt[rs2] == CNT_ONE);
    assign haz_rd  = d_rw && (cnt[rd] == CNT_MAX);
    assign hazard  = haz1 || haz2 || haz_rd;
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : (byp1 ? bus.wd_reg_data : rf[rs1]);
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : (byp2 ? bus.wd_reg_data : rf[rs2]);

    assign issue = !empty && !hazard && !bus.ex_flush_en && (!bus.de_valid || bus.de_ready);

    // architectural register write; contents survive reset, x0 is masked on read
    always_ff @(posedge clk) begin
        if (wb_fire) begin
            rf[bus.wd_rd] <= bus.wd_reg_data;
        end
    end

    // pending counters: up on issue of a writer, down on writeback, saturating at zero
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if ((issue && d_rw && rd == 5'(i)) &&
                    !(wb_fire && bus.wd_rd == 5'(i) && cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (!(issue && d_rw && rd == 5'(i)) &&
                             (wb_fire && bus.wd_rd == 5'(i) && cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
        end
    end

    // decode output register: loads on issue, holds under back-pressure, drops on flush
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            bus.de_valid     <= 1'b0;
            bus.de_alu_op    <= '0;
            bus.de_rs1_value <= '0;
            bus.de_rs2_value <= '0;
            bus.de_imm       <= '0;
            bus.de_pc        <= '0;
            bus.de_rd        <= '0;
            bus.de_reg_write <= 1'b0;
            bus.de_mem_read  <= 1'b0;
            bus.de_mem_write <= 1'b0;
            bus.de_is_br     <= 1'b0;
            bus.de_jump      <= 1'b0;
            bus.de_illegal   <= 1'b0;
        end else if (issue) begin
            bus.de_valid     <= 1'b1;
            bus.de_alu_op    <= d_alu;
            bus.de_rs1_value <= rs1_val;
            bus.de_rs2_value <= rs2_val;
            bus.de_imm       <= d_imm;
            bus.de_pc        <= h_pc;
            bus.de_rd        <= rd;
            bus.de_reg_write <= d_rw;
            bus.de_mem_read  <= d_mr;
            bus.de_mem_write <= d_mw;
            bus.de_is_br     <= d_br;
            bus.de_jump      <= h_jump;
            bus.de_illegal   <= d_ill;
        end else if (bus.ex_flush_en || bus.de_ready) begin
            bus.de_valid     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_core_id_sb.sv
// tb/tb_core_id_sb.sv - table-driven and scoreboard checks for core_id_sb
module tb_core_id_sb;
    logic clk = 1'b0;
    logic rest;
    always #5 clk = ~clk;

    core_id_sb_if bus ();
    core_id_sb_if bus0 ();

    core_id_sb #(.FIFO_DEPTH(4), .MAX_INFLIGHT(3), .BYPASS_EN(1)) dut (
        .clk (clk), .rest (rest), .bus (bus.slave)
    );
    core_id_sb #(.FIFO_DEPTH(4), .MAX_INFLIGHT(3), .BYPASS_EN(0)) dut_nb (
        .clk (clk), .rest (rest), .bus (bus0.slave)
    );

    assign bus0.fd_valid     = bus.fd_valid;
    assign bus0.fd_istr      = bus.fd_istr;
    assign bus0.fd_pc        = bus.fd_pc;
    assign bus0.fd_jump      = bus.fd_jump;
    assign bus0.ex_flush_en  = bus.ex_flush_en;
    assign bus0.wd_valid     = bus.wd_valid;
    assign bus0.wd_reg_write = bus.wd_reg_write;
    assign bus0.wd_rd        = bus.wd_rd;
    assign bus0.wd_reg_data  = bus.wd_reg_data;
    assign bus0.de_ready     = bus.de_ready;

    typedef struct {
        logic [31:0] istr;
        logic [31:0] pc;
        logic        jump;
        logic [3:0]  alu;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw, mr, mw, br, ill;
        logic        chk_rs;
        logic [31:0] rs1v, rs2v;
    } exp_t;

    int          pass_cnt = 0;
    int          tot_cnt  = 0;
    exp_t        sb_q[$];
    exp_t        cur_exp;
    exp_t        mon_e;
    logic [31:0] pc_ctr;
    exp_t        vec[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] istr, input logic [3:0] alu, input logic [31:0] imm,
                                input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                                input logic br, input logic ill);
        exp_t e;
        e.istr = istr; e.pc = '0; e.jump = 1'b0; e.alu = alu; e.imm = imm; e.rd = rd;
        e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.ill = ill;
        e.chk_rs = 1'b0; e.rs1v = '0; e.rs2v = '0;
        return e;
    endfunction

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'd0, rd, 7'h13};
    endfunction

    function automatic exp_t addi(input logic [4:0] rd, input logic [11:0] imm);
        return mk(enc_addi(rd, imm), 4'd0, {{20{imm[11]}}, imm}, rd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic exp_t with_rs(input exp_t e, input logic [31:0] v1, input logic [31:0] v2);
        exp_t r;
        r = e; r.chk_rs = 1'b1; r.rs1v = v1; r.rs2v = v2;
        return r;
    endfunction

    // scoreboard: record accepted pushes, compare on every decode handshake
    always @(negedge clk) begin
        if (!rest) begin
            sb_q.delete();
        end else begin
            if (bus.de_valid && bus.de_ready) begin
                if (sb_q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL unexpected_issue: got pc %h expected no output", bus.de_pc);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk($sformatf("alu[%h]", mon_e.istr), 32'(bus.de_alu_op), 32'(mon_e.alu));
                    chk($sformatf("imm[%h]", mon_e.istr), bus.de_imm, mon_e.imm);
                    chk($sformatf("rd[%h]", mon_e.istr), 32'(bus.de_rd), 32'(mon_e.rd));
                    chk($sformatf("flags[%h]", mon_e.istr),
                        {27'd0, bus.de_reg_write, bus.de_mem_read, bus.de_mem_write, bus.de_is_br, bus.de_illegal},
                        {27'd0, mon_e.rw, mon_e.mr, mon_e.mw, mon_e.br, mon_e.ill});
                    chk($sformatf("pc[%h]", mon_e.istr), bus.de_pc, mon_e.pc);
                    chk($sformatf("jump[%h]", mon_e.istr), 32'(bus.de_jump), 32'(mon_e.jump));
                    if (mon_e.chk_rs) begin
                        chk($sformatf("rs1[%h]", mon_e.istr), bus.de_rs1_value, mon_e.rs1v);
                        chk($sformatf("rs2[%h]", mon_e.istr), bus.de_rs2_value, mon_e.rs2v);
                    end
                end
            end
            if (bus.ex_flush_en) sb_q.delete();
            else if (bus.fd_valid && bus.fd_ready) sb_q.push_back(cur_exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input exp_t e_in, input int budget, output bit ok);
        exp_t e;
        e = e_in;
        e.pc = pc_ctr; e.jump = pc_ctr[2]; pc_ctr += 32'd4;
        cur_exp = e;
        bus.fd_valid = 1'b1; bus.fd_istr = e.istr; bus.fd_pc = e.pc; bus.fd_jump = e.jump;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            ok = bus.fd_ready && !bus.ex_flush_en;
            tick();
        end
        bus.fd_valid = 1'b0;
    endtask

    task automatic push(input exp_t e, input string nm);
        bit ok;
        offer(e, 50, ok);
        chk({nm, "_accept"}, 32'(ok), 32'd1);
    endtask

    task automatic drain(input string nm, input int budget);
        for (int c = 0; c < budget && sb_q.size() != 0; c++) tick();
        chk({nm, "_drain_left"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        bus.wd_valid = 1'b1; bus.wd_reg_write = 1'b1; bus.wd_rd = rd; bus.wd_reg_data = data;
        tick();
        bus.wd_valid = 1'b0; bus.wd_reg_write = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        bus.fd_valid = 1'b0; bus.ex_flush_en = 1'b0; bus.wd_valid = 1'b0;
        rest = 1'b0;
        #1;
        chk({nm, "_rst_de_valid"}, 32'(bus.de_valid), 32'd0);
        chk({nm, "_rst_de_imm"}, bus.de_imm, 32'd0);
        repeat (2) tick();
        rest = 1'b1;
        tick();
        chk({nm, "_rst_fd_ready"}, 32'(bus.fd_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit   ok;
        int   acc;
        logic [31:0] first_pc;

        vec[0]  = mk(32'h00500093, 4'd0, 32'h00000005, 5'd1,  1, 0, 0, 0, 0);
        vec[1]  = mk(32'hFFC12183, 4'd0, 32'hFFFFFFFC, 5'd3,  1, 1, 0, 0, 0);
        vec[2]  = mk(32'h40B50233, 4'd1, 32'h00000000, 5'd4,  1, 0, 0, 0, 0);
        vec[3]  = mk(32'h40B552B3, 4'd7, 32'h00000000, 5'd5,  1, 0, 0, 0, 0);
        vec[4]  = mk(32'h00B52423, 4'd0, 32'h00000008, 5'd8,  0, 0, 1, 0, 0);
        vec[5]  = mk(32'hFEB50CE3, 4'd0, 32'hFFFFFFF8, 5'd25, 0, 0, 0, 1, 0);
        vec[6]  = mk(32'h0100036F, 4'd0, 32'h00000010, 5'd6,  1, 0, 0, 0, 0);
        vec[7]  = mk(32'h123453B7, 4'd0, 32'h12345000, 5'd7,  1, 0, 0, 0, 0);
        vec[8]  = mk(32'hFFFFF417, 4'd0, 32'hFFFFF000, 5'd8,  1, 0, 0, 0, 0);
        vec[9]  = mk(32'hFFFFFFFF, 4'd0, 32'h00000000, 5'd31, 0, 0, 0, 0, 1);
        vec[10] = mk(32'h02B50233, 4'd0, 32'h00000000, 5'd4,  0, 0, 0, 0, 1);
        vec[11] = mk(32'hFFF53493, 4'd4, 32'hFFFFFFFF, 5'd9,  1, 0, 0, 0, 0);
        vec[12] = mk(32'h0F007113, 4'd9, 32'h000000F0, 5'd2,  1, 0, 0, 0, 0);

        bus.fd_valid = 1'b0; bus.fd_istr = '0; bus.fd_pc = '0; bus.fd_jump = 1'b0;
        bus.ex_flush_en = 1'b0; bus.wd_valid = 1'b0; bus.wd_reg_write = 1'b0;
        bus.wd_rd = '0; bus.wd_reg_data = '0; bus.de_ready = 1'b1;
        pc_ctr = 32'h00001000;
        cur_exp = vec[0];
        rest = 1'b0;
        repeat (2) tick();
        chk("reset_de_valid", 32'(bus.de_valid), 32'd0);
        chk("reset_de_pc", bus.de_pc, 32'd0);
        chk("reset_de_alu", 32'(bus.de_alu_op), 32'd0);
        rest = 1'b1;
        tick();
        chk("reset_fd_ready", 32'(bus.fd_ready), 32'd1);

        // minimum latency: pushed at edge N, valid after edge N+1
        push(vec[0], "lat");
        chk("lat_edge_n", 32'(bus.de_valid), 32'd0);
        tick();
        chk("lat_edge_n1", 32'(bus.de_valid), 32'd1);
        chk("lat_imm", bus.de_imm, 32'd5);

        // decode table
        for (int i = 1; i < 13; i++) push(vec[i], $sformatf("vec%0d", i));
        push(mk(32'h00351613, 4'd2, 32'h00000003, 5'd12, 1, 0, 0, 0, 0), "slli");
        push(mk(32'h00B52063, 4'd0, 32'h00000000, 5'd0,  0, 0, 0, 0, 1), "br_bad_f3");
        drain("table", 60);
        do_reset("a");

        // RAW stall and bypass on the writeback cycle
        push(addi(5'd1, 12'd7), "byp_w");
        push(with_rs(mk(32'h00108133, 4'd0, 32'd0, 5'd2, 1, 0, 0, 0, 0), 32'd7, 32'd7), "byp_add");
        repeat (3) tick();
        chk("byp_stalled", 32'(bus.de_valid), 32'd0);
        chk("nobyp_stalled", 32'(bus0.de_valid), 32'd0);
        wb(5'd1, 32'd7);
        chk("byp_issue_same_cycle", 32'(bus.de_valid), 32'd1);
        chk("nobyp_still_waiting", 32'(bus0.de_valid), 32'd0);
        tick();
        chk("nobyp_issue_next", 32'(bus0.de_valid), 32'd1);
        chk("nobyp_rs1", bus0.de_rs1_value, 32'd7);
        chk("nobyp_rs2", bus0.de_rs2_value, 32'd7);
        drain("byp", 10);
        do_reset("b");

        // back-pressure: buffer plus output register absorb FIFO_DEPTH+1
        bus.de_ready = 1'b0;
        acc = 0;
        first_pc = pc_ctr;
        for (int i = 0; i < 6; i++) begin
            offer(addi(5'(10 + i), 12'(i + 1)), 3, ok);
            acc += int'(ok);
        end
        chk("bp_accepted", 32'(acc), 32'd5);
        chk("bp_fd_ready", 32'(bus.fd_ready), 32'd0);
        repeat (4) tick();
        chk("bp_hold_valid", 32'(bus.de_valid), 32'd1);
        chk("bp_hold_imm", bus.de_imm, 32'd1);
        chk("bp_hold_rd", 32'(bus.de_rd), 32'd10);
        chk("bp_hold_pc", bus.de_pc, first_pc);
        bus.de_ready = 1'b1;
        drain("bp", 30);

        // flush with three buffered and one presented; scoreboard must survive
        bus.de_ready = 1'b0;
        push(addi(5'd20, 12'd3), "fl_w");
        for (int i = 0; i < 3; i++) push(addi(5'(21 + i), 12'd1), "fl_buf");
        bus.ex_flush_en = 1'b1;
        cur_exp = addi(5'd24, 12'd2);
        bus.fd_valid = 1'b1; bus.fd_istr = cur_exp.istr;
        tick();
        bus.ex_flush_en = 1'b0; bus.fd_valid = 1'b0;
        chk("fl_de_valid", 32'(bus.de_valid), 32'd0);
        chk("fl_fd_ready", 32'(bus.fd_ready), 32'd1);
        bus.de_ready = 1'b1;
        repeat (3) tick();
        chk("fl_empty", 32'(bus.de_valid), 32'd0);
        push(with_rs(mk(32'h014A0CB3, 4'd0, 32'd0, 5'd25, 1, 0, 0, 0, 0), 32'd33, 32'd33), "fl_add");
        repeat (3) tick();
        chk("fl_cnt_kept", 32'(bus.de_valid), 32'd0);
        wb(5'd20, 32'd33);
        drain("fl", 10);
        do_reset("c");

        // in-flight limit on one destination
        for (int i = 0; i < 4; i++) push(addi(5'd5, 12'(i + 1)), "inf");
        repeat (3) tick();
        chk("inf_stall", 32'(bus.de_valid), 32'd0);
        chk("inf_pending", 32'(sb_q.size()), 32'd1);
        wb(5'd5, 32'd1);
        chk("inf_wb_cycle", 32'(bus.de_valid), 32'd0);
        tick();
        chk("inf_release", 32'(bus.de_valid), 32'd1);
        tick();

        // reset while stalled: pending state discarded, register file kept
        push(addi(5'd5, 12'd9), "rst_stall");
        repeat (2) tick();
        do_reset("d");
        push(with_rs(mk(32'h00528733, 4'd0, 32'd0, 5'd14, 1, 0, 0, 0, 0), 32'd1, 32'd1), "post_rst");
        drain("post_rst", 10);
        repeat (3) tick();
        chk("post_rst_idle", 32'(bus.de_valid), 32'd0);

        // writeback with nothing pending must not underflow
        wb(5'd7, 32'h55);
        wb(5'd7, 32'h55);
        push(with_rs(mk(32'h000386B3, 4'd0, 32'd0, 5'd13, 1, 0, 0, 0, 0), 32'h55, 32'd0), "sat");
        drain("sat", 10);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
